// File: rtl/matmul_accum_requant.sv
`default_nettype none
// ============================================================================
// matmul_accum_requant : accumulates len signed products per group, then
// requantizes (shift / optional round / saturate) behind a valid/ready port.
// Optional feature macro: MATMUL_ACC_ROUND_EN (round half toward +inf).
// Revision: 1.0
// ============================================================================
module matmul_accum_requant #(
  parameter int IN_WIDTH   = 55,
  parameter int ACC_WIDTH  = 64,
  parameter int OUT_WIDTH  = 32,
  parameter int FRAC_SHIFT = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 ap_clk,
  input  logic                 ap_rst,
  input  logic [LEN_WIDTH-1:0] len,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sat,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACC  = 1'b1;

  localparam logic signed [ACC_WIDTH:0] MAX_OUT =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] MIN_OUT =
    {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [0:0]                  state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]        cnt;
  logic [LEN_WIDTH-1:0]        len_q;
  logic signed [ACC_WIDTH-1:0] sum_reg;
  logic                        sum_valid;

  logic                        accept;
  logic                        last;
  logic                        transfer;
  logic [LEN_WIDTH-1:0]        len_eff;
  logic [LEN_WIDTH-1:0]        len_cur;
  logic signed [ACC_WIDTH-1:0] in_ext;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic signed [ACC_WIDTH:0]   sum_ext;
  logic signed [ACC_WIDTH:0]   rounded;
  logic signed [ACC_WIDTH:0]   shifted;
  logic                        sat_hi;
  logic                        sat_lo;
  logic [OUT_WIDTH-1:0]        rq_data;
  logic                        rq_sat;

  assign transfer = sum_valid && (!out_valid || out_ready);
  // Stall only while a finished sum is stuck behind an unaccepted output.
  assign in_ready = !(sum_valid && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_ACC) || sum_valid || out_valid;

  assign len_eff  = (len == '0) ? LEN_WIDTH'(1) : len;
  assign len_cur  = (state == ST_IDLE) ? len_eff : len_q;
  assign last     = (cnt == len_cur - LEN_WIDTH'(1));
  assign in_ext   = ACC_WIDTH'($signed(in_data));
  assign acc_next = acc + in_ext;

  assign sum_ext = {sum_reg[ACC_WIDTH-1], sum_reg};
`ifdef MATMUL_ACC_ROUND_EN
  localparam logic signed [ACC_WIDTH:0] RND_HALF =
    {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_SHIFT-1);
  assign rounded = sum_ext + RND_HALF;
`else
  assign rounded = sum_ext;
`endif
  assign shifted = rounded >>> FRAC_SHIFT;
  assign sat_hi  = (shifted > MAX_OUT);
  assign sat_lo  = (shifted < MIN_OUT);
  assign rq_sat  = sat_hi || sat_lo;
  assign rq_data = sat_hi ? MAX_OUT[OUT_WIDTH-1:0] :
                   sat_lo ? MIN_OUT[OUT_WIDTH-1:0] :
                            shifted[OUT_WIDTH-1:0];

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (accept) begin
      if (state == ST_IDLE) begin
        len_q <= len_eff;
      end
      if (last) begin
        state <= ST_IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        state <= ST_ACC;
        acc   <= acc_next;
        cnt   <= cnt + LEN_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      sum_reg   <= '0;
      sum_valid <= 1'b0;
    end else if (accept && last) begin
      sum_reg   <= acc_next;
      sum_valid <= 1'b1;
    end else if (transfer) begin
      sum_valid <= 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (transfer) begin
      out_data  <= rq_data;
      out_sat   <= rq_sat;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matmul_accum_requant.sv
`default_nettype none
// ============================================================================
// tb_matmul_accum_requant : directed self-checking bench for the
// accumulate/requantize block, default parameters (FRAC_SHIFT = 16).
// Revision: 1.0
// ============================================================================
module tb_matmul_accum_requant;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [15:0] len;
  logic [54:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int tests = 0;
  int fails = 0;

  matmul_accum_requant dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .len       (len),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // One len=1 group: result must appear one edge after the beat, then drain.
  task automatic run1(input string tag, input logic [54:0] d,
                      input logic [31:0] exp_data, input logic exp_sat);
    len      = 16'd1;
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"},  64'(out_data),  64'(exp_data));
    chk({tag, "_sat"},   64'(out_sat),   64'(exp_sat));
    tick();
    chk({tag, "_drain"}, 64'(out_valid), 64'd0);
  endtask

  logic [31:0] exp_pos_rnd;
  logic [31:0] exp_neg_rnd;

  initial begin
`ifdef MATMUL_ACC_ROUND_EN
    exp_pos_rnd = 32'd2;
    exp_neg_rnd = 32'hFFFF_FFFF;
`else
    exp_pos_rnd = 32'd1;
    exp_neg_rnd = 32'hFFFF_FFFE;
`endif
    ap_rst    = 1'b1;
    len       = 16'd0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_sat",   64'(out_sat),   64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    tick();
    tick();
    ap_rst = 1'b0;

    // len=3 dot product: (1+2+3) * 2^16 -> 6
    len = 16'd3; in_valid = 1'b1; in_data = 55'h10000;
    tick();
    in_data = 55'h20000;
    tick();
    chk("g3_busy", 64'(busy), 64'd1);
    in_data = 55'h30000;
    tick();
    in_valid = 1'b0;
    chk("g3_not_yet", 64'(out_valid), 64'd0);
    tick();
    chk("g3_valid", 64'(out_valid), 64'd1);
    chk("g3_data",  64'(out_data),  64'd6);
    chk("g3_sat",   64'(out_sat),   64'd0);
    tick();
    chk("g3_drain", 64'(out_valid), 64'd0);
    chk("g3_idle",  64'(busy),      64'd0);

    // Rounding vs truncation, then saturation in both directions
    run1("pos_half", 55'h18000, exp_pos_rnd, 1'b0);
    run1("neg_half", -55'sh18000, exp_neg_rnd, 1'b0);
    run1("sat_hi", {1'b0, {54{1'b1}}}, 32'h7FFF_FFFF, 1'b1);
    run1("sat_lo", {1'b1, {54{1'b0}}}, 32'h8000_0000, 1'b1);

    // len=0 acts as 1; back-to-back beats give results on consecutive cycles
    len = 16'd0; in_valid = 1'b1; in_data = 55'h10000;
    tick();
    in_data = 55'h20000;
    tick();
    in_valid = 1'b0;
    chk("l0_v1", 64'(out_valid), 64'd1);
    chk("l0_d1", 64'(out_data),  64'd1);
    tick();
    chk("l0_v2", 64'(out_valid), 64'd1);
    chk("l0_d2", 64'(out_data),  64'd2);
    tick();
    chk("l0_drain", 64'(out_valid), 64'd0);

    // Backpressure: two len=2 groups with out_ready low
    out_ready = 1'b0; len = 16'd2; in_valid = 1'b1; in_data = 55'h8000;
    tick();
    tick();
    chk("bp_rdy_a", 64'(in_ready), 64'd1);
    in_data = 55'h10000;
    tick();
    chk("bp_d1_early", 64'(out_data), 64'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_rdy_low", 64'(in_ready), 64'd0);
    tick();
    chk("bp_hold_v", 64'(out_valid), 64'd1);
    chk("bp_hold_d", 64'(out_data),  64'd1);
    chk("bp_rdy_low2", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_comb", 64'(in_ready), 64'd1);
    tick();
    chk("bp_v2", 64'(out_valid), 64'd1);
    chk("bp_d2", 64'(out_data),  64'd2);
    tick();
    chk("bp_drain", 64'(out_valid), 64'd0);

    // Reset mid-group discards partial sum
    len = 16'd4; in_valid = 1'b1; in_data = 55'h10000;
    tick();
    tick();
    chk("mr_busy", 64'(busy), 64'd1);
    ap_rst = 1'b1;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_busy0",     64'(busy),      64'd0);
    chk("mr_in_ready",  64'(in_ready),  64'd1);
    chk("mr_out_data",  64'(out_data),  64'd0);
    in_valid = 1'b0;
    tick();
    ap_rst = 1'b0;
    tick();
    run1("after_rst", 55'h50000, 32'd5, 1'b0);
    tick();
    chk("after_rst_quiet", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/matmul_accum_requant.md
# matmul_accum_requant

Downstream consumer of the kernel's signed-by-unsigned product multiplier. Takes a stream of 55-bit signed products, accumulates `len` of them into one dot-product sum, then requantizes the sum to a signed fixed-point output: arithmetic right shift, optional rounding, saturation. The output goes to the result write-back path through a valid/ready handshake.

## Interface
- `IN_WIDTH`, 55: signed product width from the multiplier.
- `ACC_WIDTH`, 64: signed accumulator width. Must be ≥ IN_WIDTH.
- `OUT_WIDTH`, 32: signed result width.
- `FRAC_SHIFT`, 16: right-shift amount applied at requantization. Must be ≥ 1.
- `LEN_WIDTH`, 16: width of the dot-product length.
- `ap_clk`, in, 1: single clock. All state is rising-edge.
- `ap_rst`, in, 1: reset. Asynchronous, active-high.
- `len`, in, LEN_WIDTH: products per group. Sampled on the first accepted beat of a group. A value of 0 is treated as 1.
- `in_data`, in, IN_WIDTH: signed product.
- `in_valid`, in, 1: `in_data` is valid.
- `in_ready`, out, 1: the block accepts a beat this cycle.
- `out_data`, out, OUT_WIDTH: requantized signed result.
- `out_sat`, out, 1: `out_data` was clamped. Qualified by `out_valid`.
- `out_valid`, out, 1: result is valid.
- `out_ready`, in, 1: downstream accepts the result.
- `busy`, out, 1: a group is in progress, or the sum or output register is occupied.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- FSM states:
  - IDLE: no group open. `acc` = 0, `cnt` = 0. The first accepted beat latches `len_q` (0→1) and moves to ACC.
  - ACC: group open. In both states, each accepted beat does `acc += sext(in_data)` and `cnt += 1`.
- When the accepted beat satisfies `cnt == len_q-1` (including the first beat when `len_q == 1`):
  - `sum_reg <= acc + sext(in_data)`, `sum_valid <= 1`.
  - `acc` and `cnt` clear.
  - FSM returns to IDLE.
- The accumulator wraps two's complement in ACC_WIDTH bits. It never saturates.
- Transfer to the output register happens when `sum_valid && (!out_valid || out_ready)`. On transfer:
  - `out_data` and `out_sat` load from requant(`sum_reg`), `out_valid <= 1`, `sum_valid <= 0`.
  - If a new sum lands in the same cycle, `sum_valid` stays 1.
- When `out_valid && out_ready` and no transfer occurs, `out_valid <= 0`.
- `in_ready = !(sum_valid && out_valid && !out_ready)`. This is a combinational path from `out_ready`. Every beat stalls while a completed sum cannot move forward.
- Requantization, computed in ACC_WIDTH+1 bits:
  - Add `2^(FRAC_SHIFT-1)` if rounding is enabled.
  - Arithmetic shift right by FRAC_SHIFT.
  - Clamp to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. `out_sat` = 1 if clamped.
- `busy = (state == ACC) || sum_valid || out_valid`.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_sat` = 0, `busy` = 0. Internally: state IDLE, `acc`/`cnt`/`sum_valid` = 0.
- Reset asserted mid-group discards the partial sum, any held sum and any pending output. No output is produced for that group.
- Latency: last beat accepted at edge T → `out_valid` = 1 after edge T+1, provided the output register is free or drained at T+1.
- Throughput: one beat per cycle. Back-to-back groups of `len` = 1 sustain one result per cycle while `out_ready` = 1.
- `out_data` and `out_sat` hold stable while `out_valid && !out_ready`.
- `len` changes mid-group are ignored until the next group starts.

## Configuration
- `MATMUL_ACC_ROUND_EN` defined: add half-LSB before the shift (round half toward +∞).
- Not defined: pure arithmetic shift (truncate toward −∞). No rounding adder is instantiated.

## Test plan
All scenarios use default parameters, FRAC_SHIFT = 16.
- `len` = 3; beats 0x10000, 0x20000, 0x30000; `out_ready` = 1 → one result, `out_data` = 6, `out_sat` = 0, `out_valid` 2 cycles after the last beat.
- `len` = 1; beat 0x18000 → 2 with `MATMUL_ACC_ROUND_EN`, 1 without. Beat −0x18000 → −1 with, −2 without.
- `len` = 1; beat 2^54−1 → `out_data` = 0x7FFFFFFF, `out_sat` = 1. Beat −2^54 → `out_data` = 0x80000000, `out_sat` = 1.
- `len` = 0 (treated as 1); beats 0x10000, 0x20000 back to back → results 1 then 2 on consecutive cycles.
- `out_ready` = 0; two `len` = 2 groups streamed → `in_ready` falls after the second group completes. Results 1 and 2 are then delivered in order once `out_ready` rises; `out_data` stays stable while stalled.
- `ap_rst` pulsed after 2 of 4 beats → outputs return to reset values immediately. A following `len` = 1 group with beat 0x50000 yields 5 only.
